// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared pipeline constants, exception codes and stage action type
package pipe_stage_reg_pkg;

    // Exception code width and the "no exception" code.
    localparam int              EXC_W      = 5;
    localparam logic [EXC_W-1:0] EXC_NONE  = '0;

    // PC loaded when an exception/interrupt request flushes the pipe.
    localparam logic [31:0]     HANDLER_PC = 32'h0000_4180;

    // Stall behaviour encodings.
    localparam int              STALL_HOLD   = 0;
    localparam int              STALL_BUBBLE = 1;

    // Exception codes carried down the pipe (MIPS-style cause values).
    typedef enum logic [EXC_W-1:0] {
        EXC_CODE_NONE = 5'd0,
        EXC_ADEL      = 5'd4,
        EXC_ADES      = 5'd5,
        EXC_SYS       = 5'd8,
        EXC_BP        = 5'd9,
        EXC_RI        = 5'd10,
        EXC_OV        = 5'd12
    } exc_code_e;

    // The single action a stage register takes on a clock edge (reset handled separately).
    typedef enum logic [1:0] {
        ACT_REQ,
        ACT_FLUSH,
        ACT_STALL,
        ACT_ADVANCE
    } stage_act_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - data-in / registered-out bundle of one pipeline stage register
interface pipe_stage_reg_if #(
    parameter int PAYLOAD_W = 128,
    parameter int EXC_W     = 5,
    parameter int CNT_W     = 16
);
    logic                 in_valid;
    logic [31:0]          in_pc;
    logic                 in_bd;
    logic [EXC_W-1:0]     in_exc_prev;
    logic [EXC_W-1:0]     in_exc_local;
    logic [PAYLOAD_W-1:0] in_payload;

    logic                 out_valid;
    logic [31:0]          out_pc;
    logic                 out_bd;
    logic [EXC_W-1:0]     out_exc;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [CNT_W-1:0]     bubble_cnt;

    // Upstream stage drives the in_* fields and observes the outputs.
    modport master (
        output in_valid, in_pc, in_bd, in_exc_prev, in_exc_local, in_payload,
        input  out_valid, out_pc, out_bd, out_exc, out_payload, bubble_cnt
    );

    // The stage register itself.
    modport slave (
        input  in_valid, in_pc, in_bd, in_exc_prev, in_exc_local, in_payload,
        output out_valid, out_pc, out_bd, out_exc, out_payload, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_reg_exc_merge.sv
// rtl/pipe_stage_reg_exc_merge.sv - oldest-exception-wins merge shared by all stage registers
module exc_merge import pipe_stage_reg_pkg::*; #(
    parameter int EXC_W = pipe_stage_reg_pkg::EXC_W
) (
    input  logic             valid_i,
    input  logic [EXC_W-1:0] exc_prev_i,
    input  logic [EXC_W-1:0] exc_local_i,
    output logic [EXC_W-1:0] exc_o
);
    // An exception from further upstream is older, so it beats the local one;
    // an invalid slot never carries an exception ('0 is the "none" code at any width).
    always_comb begin
        exc_o = '0;
        if (valid_i) begin
            exc_o = (exc_prev_i != '0) ? exc_prev_i : exc_local_i;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with req/flush/stall handling and bubble counter
module pipe_stage_reg import pipe_stage_reg_pkg::*; #(
    parameter int          PAYLOAD_W  = 128,
    parameter int          EXC_W      = pipe_stage_reg_pkg::EXC_W,
    parameter logic [31:0] HANDLER_PC = pipe_stage_reg_pkg::HANDLER_PC,
    parameter int          STALL_MODE = STALL_HOLD,
    parameter int          CNT_W      = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req,
    input  logic           flush,
    input  logic           stall,
    pipe_stage_reg_if.slave sif
);
    // Registered state; initialisers give all-zero outputs from time zero.
    logic                 valid_q   = 1'b0;
    logic [31:0]          pc_q      = '0;
    logic                 bd_q      = 1'b0;
    logic [EXC_W-1:0]     exc_q     = '0;
    logic [PAYLOAD_W-1:0] payload_q = '0;
    logic [CNT_W-1:0]     cnt_q     = '0;

    logic                 valid_d;
    logic [31:0]          pc_d;
    logic                 bd_d;
    logic [EXC_W-1:0]     exc_d;
    logic [PAYLOAD_W-1:0] payload_d;
    logic [CNT_W-1:0]     cnt_d;

    stage_act_e           act;
    logic                 bubble;
    logic [EXC_W-1:0]     merged_exc;

    exc_merge #(
        .EXC_W (EXC_W)
    ) u_exc_merge (
        .valid_i     (sif.in_valid),
        .exc_prev_i  (sif.in_exc_prev),
        .exc_local_i (sif.in_exc_local),
        .exc_o       (merged_exc)
    );

    // Pick the one action for this edge: req > flush > stall > advance.
    always_comb begin
        act = ACT_ADVANCE;
        if (req) begin
            act = ACT_REQ;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else if (stall) begin
            act = ACT_STALL;
        end
    end

    // Next-state contents and bubble accounting for the selected action.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        bd_d      = bd_q;
        exc_d     = exc_q;
        payload_d = payload_q;
        bubble    = 1'b0;
        case (act)
            ACT_REQ: begin
                valid_d   = 1'b0;
                pc_d      = HANDLER_PC;
                bd_d      = 1'b0;
                exc_d     = '0;
                payload_d = '0;
            end
            ACT_FLUSH: begin
                valid_d   = 1'b0;
                pc_d      = sif.in_pc;
                bd_d      = 1'b0;
                exc_d     = '0;
                payload_d = '0;
                bubble    = 1'b1;
            end
            ACT_STALL: begin
                // In bubble mode the PC/BD still track the input so an interrupt
                // landing on the bubble reports the right EPC and delay-slot bit.
                if (STALL_MODE == STALL_BUBBLE) begin
                    valid_d   = 1'b0;
                    pc_d      = sif.in_pc;
                    bd_d      = sif.in_bd;
                    exc_d     = '0;
                    payload_d = '0;
                    bubble    = 1'b1;
                end
            end
            ACT_ADVANCE: begin
                valid_d   = sif.in_valid;
                pc_d      = sif.in_pc;
                bd_d      = sif.in_bd;
                exc_d     = merged_exc;
                payload_d = sif.in_payload;
                bubble    = ~sif.in_valid;
            end
            default: begin
            end
        endcase
        cnt_d = cnt_q;
        if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State register; reset overrides every other action.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            bd_q      <= 1'b0;
            exc_q     <= '0;
            payload_q <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            bd_q      <= bd_d;
            exc_q     <= exc_d;
            payload_q <= payload_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sif.out_valid   = valid_q;
    assign sif.out_pc      = pc_q;
    assign sif.out_bd      = bd_q;
    assign sif.out_exc     = exc_q;
    assign sif.out_payload = payload_q;
    assign sif.bubble_cnt  = cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter PAYLOAD_W, 128, width of the opaque stage payload (instr, result, write data, imm, HI/LO).
REQ-002 SHALL have parameter EXC_W, 5, exception code width; code 0 means no exception.
REQ-003 SHALL have parameter HANDLER_PC, 32'h0000_4180, PC loaded on exception request.
REQ-004 SHALL have parameter STALL_MODE, 0, where 0 holds the stage on stall and 1 inserts a bubble on stall.
REQ-005 SHALL have parameter CNT_W, 16, bubble counter width.
REQ-006 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port req, input, 1, exception/interrupt request (flush to handler).
REQ-009 SHALL have port flush, input, 1, ordinary flush (e.g. ERET), which inserts a bubble.
REQ-010 SHALL have port stall, input, 1, stall from the hazard unit.
REQ-011 SHALL have the following data-in ports: in_valid (1), in_pc (32), in_bd (1), in_exc_prev (EXC_W, upstream exception code), in_exc_local (EXC_W, exception raised in the feeding stage), in_payload (PAYLOAD_W).
REQ-012 SHALL have the following registered outputs: out_valid (1), out_pc (32), out_bd (1), out_exc (EXC_W), out_payload (PAYLOAD_W), bubble_cnt (CNT_W).

Function
REQ-013 SHALL evaluate one action per clk edge in this priority order: reset > req > flush > stall > advance.
REQ-014 On req, the stage SHALL load: out_pc = HANDLER_PC, out_valid = 0, out_bd = 0, out_exc = 0, out_payload = 0.
REQ-015 On flush without req, the stage SHALL load: out_valid = 0, out_exc = 0, out_bd = 0, out_payload = 0, and out_pc = in_pc.
REQ-016 On stall with STALL_MODE=0, every output except bubble_cnt SHALL hold its value.
REQ-017 On stall with STALL_MODE=1, the stage SHALL load a bubble (out_valid = 0, out_exc = 0, out_payload = 0) but SHALL keep out_pc = in_pc and out_bd = in_bd, so that EPC/BD stay correct if an interrupt hits the bubble.
REQ-018 On advance, the stage SHALL load all in_* fields, with out_exc = (in_exc_prev != 0) ? in_exc_prev : in_exc_local, so the oldest exception wins.
REQ-019 On advance with in_valid = 0, the stage SHALL force out_exc = 0 whatever the exception inputs are.
REQ-020 bubble_cnt SHALL increment by 1 on each edge where a bubble is loaded (flush, or stall with STALL_MODE=1, or advance with in_valid = 0), SHALL saturate at all-ones, and SHALL NOT count req edges.
REQ-021 With req and stall both asserted, req SHALL win; with flush and stall both asserted, flush SHALL win.
REQ-022 There SHALL be no combinational path from any input to any output; latency is exactly 1 cycle.

Reset
REQ-023 On reset, all outputs SHALL be 0 (out_pc = 0, out_valid = 0, out_bd = 0, out_exc = 0, out_payload = 0, bubble_cnt = 0) on the next edge, regardless of req, flush or stall.
REQ-024 Reset asserted mid-stall SHALL discard the held contents; after release the stage SHALL resume on the first edge at which reset is low.
REQ-025 Outputs SHALL also start at 0 at time zero in simulation.

Structure
REQ-026 EXC_W, the code value EXC_NONE = 0, HANDLER_PC and the STALL_MODE encodings SHALL live in the shared pipeline package, alongside the exception codes.
REQ-027 The exception-merge logic (REQ-018/019) SHALL be a sub-module exc_merge, which the F/D, D/E, E/M and M/W instances reuse.
REQ-028 The block SHALL contain no other sub-modules; a single always block of sequential logic is sufficient.

Verification
REQ-029 Apply reset for 2 cycles, then release with in_valid = 1, in_pc = 0x3000 -> after 1 edge out_pc = 0x3000 and out_valid = 1; during reset all outputs are 0.
REQ-030 Apply req = 1 together with stall = 1 and in_pc = 0x3008 -> out_pc = 0x4180, out_valid = 0, out_exc = 0, bubble_cnt unchanged.
REQ-031 Apply in_exc_prev = 4 and in_exc_local = 12 -> out_exc = 4; apply in_exc_prev = 0 and in_exc_local = 12 -> out_exc = 12; apply in_valid = 0 -> out_exc = 0.
REQ-032 With STALL_MODE=0, stall for 3 cycles while the inputs change -> outputs are frozen at the pre-stall values and bubble_cnt does not change.
REQ-033 With STALL_MODE=1, stall with in_pc = 0x300C and in_bd = 1 -> out_valid = 0, out_pc = 0x300C, out_bd = 1, and bubble_cnt increments by 1 per stall cycle.
REQ-034 With CNT_W = 2, apply 5 consecutive flush cycles -> bubble_cnt = 3 (saturated); then assert reset -> bubble_cnt = 0.
